// File: rtl/mips_mmio_pkg.sv
// Shared constants and types for the MIPS memory-mapped I/O blocks.
// Store-bus snoop struct and the saturating drop-counter helper.
package mips_mmio_pkg;

  localparam int BUS_W = 8;
  localparam int DROP_CNT_W = 8;

  localparam logic [BUS_W-1:0] PORT_ADDR_DEF = 8'hFF;

  typedef struct packed {
    logic             memwrite;
    logic [BUS_W-1:0] adr;
    logic [BUS_W-1:0] writedata;
  } store_bus_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(
    input logic [DROP_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and occupancy count.
// A full FIFO still accepts a push when a pop happens in the same cycle.
module sync_fifo
  import mips_mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty & ~reset;
  assign push_ok = push & (~full | pop_ok) & ~reset;
  assign rdata   = mem[rptr];

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
    end else if (push_ok) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
    end else if (pop_ok) begin
      rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_out_port.sv
// Output port snooping processor stores to PORT_ADDR into a FIFO.
// Define MMIO_OUT_DROPCNT_EN to add the saturating drop_cnt output.
module mmio_out_port
  import mips_mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] PORT_ADDR = WIDTH'(PORT_ADDR_DEF),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow
`ifdef MMIO_OUT_DROPCNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic hit;
  logic pop;
  logic empty;
  logic drop;

  assign hit       = memwrite & (adr == PORT_ADDR);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  // Full with a concurrent pop is a pass-through, not a drop.
  assign drop      = hit & full & ~pop;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (hit),
    .pop   (pop),
    .wdata (writedata),
    .rdata (out_data),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef MMIO_OUT_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mmio_out_port.sv
// Scoreboard bench for mmio_out_port.
// Checks drop_cnt too when MMIO_OUT_DROPCNT_EN is defined.
module tb_mmio_out_port;
  import mips_mmio_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [W-1:0]  adr;
  logic [W-1:0]  writedata;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef MMIO_OUT_DROPCNT_EN
  logic [7:0]    drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sb [$];
  bit m_ovf = 1'b0;
  int m_drop = 0;

  always #5 clk = ~clk;

  mmio_out_port #(
    .WIDTH     (W),
    .DEPTH     (D),
    .PORT_ADDR (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
`ifdef MMIO_OUT_DROPCNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, score pop/push, then check state after the edge.
  task automatic cyc(input bit rst, input bit we,
                     input logic [7:0] a, input logic [7:0] d,
                     input bit rdy);
    bit popping;
    int pre;
    reset = rst; memwrite = we; adr = a;
    writedata = d; out_ready = rdy;
    @(negedge clk);
    pre = sb.size();
    popping = !rst && (pre != 0) && rdy;
    if (!rst && out_valid && rdy) begin
      if (pre == 0) chk("spurious_pop", 1, 0);
      else chk("pop_data", out_data, sb.pop_front());
    end
    if (rst) begin
      sb.delete();
      m_ovf = 1'b0;
      m_drop = 0;
    end else if (we && a == 8'hFF) begin
      if (pre < D || popping) sb.push_back(d);
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    @(posedge clk);
    #1;
    chk("count", count, sb.size());
    chk("valid", out_valid, sb.size() != 0);
    chk("full", full, sb.size() == D);
    chk("overflow", overflow, m_ovf);
    if (sb.size() != 0) chk("head", out_data, sb[0]);
`ifdef MMIO_OUT_DROPCNT_EN
    chk("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  task automatic st(input logic [7:0] d, input bit rdy);
    cyc(0, 1, 8'hFF, d, rdy);
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 8'h00, 8'h00, rdy);
  endtask

  logic [7:0] seq1 [4] = '{8'h01, 8'h01, 8'h02, 8'h03};
  logic [7:0] seq2 [3] = '{8'h05, 8'h08, 8'h0D};

  initial begin
    cyc(1, 0, 8'h00, 8'h00, 0);
    cyc(1, 1, 8'hFF, 8'h55, 1);

    // single store then one pop
    st(8'h0D, 0);
    idle(0);
    idle(1);
    idle(0);

    // address filter
    cyc(0, 1, 8'hFE, 8'h11, 0);
    cyc(0, 1, 8'h00, 8'h22, 0);
    cyc(0, 0, 8'hFF, 8'h33, 0);

    // ordering, full, drain, wrap
    foreach (seq1[i]) st(seq1[i], 0);
    for (int i = 0; i < 5; i++) idle(1);
    foreach (seq2[i]) st(seq2[i], 0);
    for (int i = 0; i < 4; i++) idle(1);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) st(8'h40 + 8'(i), 0);
    st(8'h77, 1);
    for (int i = 0; i < 5; i++) idle(1);

    // overflow and saturating drop count
    for (int i = 0; i < 4; i++) st(8'h60 + 8'(i), 0);
    st(8'hAA, 0);
    for (int i = 0; i < 256; i++) st(8'(i), 0);
    for (int i = 0; i < 5; i++) idle(1);

    // reset mid-stream with a push in the reset cycle
    cyc(1, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) st(8'h90 + 8'(i), 0);
    cyc(1, 1, 8'hFF, 8'hEE, 1);
    st(8'h0D, 0);
    idle(1);

    // streaming: push and pop every cycle
    for (int i = 0; i < 20; i++) st(8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < 3; i++) idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_out_port.md
# mmio_out_port

Memory-mapped output port that sits directly downstream of the `mips_mem` memory interface. It snoops every processor store, captures writes addressed to the output location (default 8'hFF), and buffers the data in a small FIFO. A consumer (bench checker, display, UART stage) drains the data over a valid/ready handshake. Results the program stores to the output address, such as the Fibonacci value 8'h0D, are therefore delivered as an ordered stream rather than sampled ad hoc.

## Interface
- `WIDTH`, 8: data and address width; matches the processor datapath.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥ 2.
- `PORT_ADDR`, 8'hFF: store address that is captured; width `WIDTH`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  processor store strobe, from the memory interface.
- `adr`  in  `WIDTH`  processor store address.
- `writedata`  in  `WIDTH`  processor store data.
- `out_data`  out  `WIDTH`  head-of-FIFO data.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  $clog2(`DEPTH`)+1  current occupancy.
- `overflow`  out  1  sticky: at least one capture was dropped.
- `drop_cnt`  out  8  saturating dropped-capture count; present only with `MMIO_OUT_DROPCNT_EN`.

## Operation
- Capture: `push = memwrite & (adr == PORT_ADDR)`. Stores to any other address are ignored.
- Pop: `pop = out_valid & out_ready`.
- Push when not full: `writedata` is written at the write pointer, and the write pointer increments.
- Pop: the read pointer increments.
- Pointers wrap modulo `DEPTH`. `count` = entries held.
- Full plus simultaneous push and pop: both are accepted, `count` is unchanged, and no drop occurs.
- Empty plus simultaneous push and pop: pop is not possible because `out_valid` = 0. The push is accepted.
- Push when full with no pop: data is discarded, `overflow` is set and stays set until reset, and `drop_cnt` increments, saturating at 8'hFF.
- `out_data` when empty: holds the last storage value. It is don't-care and must not be checked.
- Order: strict FIFO; there is no reordering or coalescing of repeated values.
- Reset: pointers = 0, `count` = 0, `out_valid` = 0, `full` = 0, `overflow` = 0, `drop_cnt` = 0. Storage contents are not cleared. Reset asserted mid-stream discards all buffered entries. A push or pop in the reset cycle is ignored.

## Timing
- Capture latency is 1 cycle. A store sampled at rising edge N appears at `out_valid`/`out_data` after edge N.
- Drain is 1 entry per cycle maximum. With `out_ready` held high, sustained throughput is 1 push and 1 pop per cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `memwrite`, `adr`, `writedata` or `out_ready` to any output.
- `out_valid` must not drop without a pop, and `out_data` must be stable while `out_valid` = 1 and `out_ready` = 0.

## Configuration
- `MMIO_OUT_DROPCNT_EN` defined: the `drop_cnt` port and its 8-bit saturating counter exist.
- `MMIO_OUT_DROPCNT_EN` undefined: the port and counter are absent. The `overflow` sticky bit remains in both builds.

## Structure
- Package `mips_mmio_pkg`:
  - default `PORT_ADDR` constant (8'hFF);
  - `DROP_CNT_W` = 8;
  - a struct typedef for the snooped store bus (`memwrite`, `adr`, `writedata`), shared with other MMIO blocks.
- Sub-module `sync_fifo` (`WIDTH`, `DEPTH`): storage, pointers and count. `mmio_out_port` adds the address decode, overflow/drop logic and the optional counter.

## Test plan
- Single store: `adr`=8'hFF, `writedata`=8'h0D for one cycle, with `out_ready`=0. Required: `out_valid`=1 and `out_data`=8'h0D from the next cycle, and `count`=1. Then `out_ready`=1 for one cycle. Required: `count`=0 and `out_valid`=0.
- Address filter: stores to 8'hFE and 8'h00 with `memwrite`=1, plus `adr`=8'hFF with `memwrite`=0. Required: `count` stays 0 and `out_valid` stays 0.
- Ordering and wrap:
  - Push 8'h01, 8'h01, 8'h02, 8'h03 with `out_ready`=0. Required: `full`=1.
  - Then drain. Required: the pops return 8'h01, 8'h01, 8'h02, 8'h03 in order.
  - Repeat with 8'h05, 8'h08, 8'h0D across the pointer wrap. Required: order is preserved.
- Overflow: fill with 4 entries, then push 8'hAA with no pop. Required: 8'hAA is dropped, `overflow`=1, and `drop_cnt`=1 (DROPCNT build). 256 further drops leave `drop_cnt`=8'hFF.
- Full with push and pop in the same cycle: push 8'h77 with `out_ready`=1. Required: `count` stays 4, `overflow` stays 0, and 8'h77 emerges last.
- Reset mid-stream: 3 entries buffered, `reset`=1 for one cycle together with a push. Required: next cycle `count`=0, `out_valid`=0, `overflow`=0. A subsequent store of 8'h0D is the first item out.
